cam_pattern_tx: RTL

CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

---
 rtl/cam_pattern_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cam_pattern_tx.sv
// Camera-style RGB444 test pattern transmitter with pclk, href and c_vsync.
// Define CAM_TX_BARS_EN to compile the colour-bar generator (pattern_sel).
module cam_pattern_tx #(
    parameter int H_ACTIVE    = 128,
    parameter int V_ACTIVE    = 128,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       enable,
    input  logic       pattern_sel,
    output logic       pclk,
    output logic       href,
    output logic       c_vsync,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int LINE = 2 * H_ACTIVE + H_BLANK;

    typedef enum logic [2:0] {
        IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT
    } state_t;

    state_t      state, nstate;
    logic        ph;
    logic        pat, npat;
    logic        ndone;
    logic [15:0] cnt, ncnt;
    logic [15:0] line, nline;
    logic [11:0] rgb;
    logic [7:0]  ndata;

    // Counters only advance on the m_clock edge where ph falls.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nline  = line;
        npat   = pat;
        ndone  = 1'b0;
        if (state == IDLE) begin
            if (enable) begin
                nstate = VSYNC;
                ncnt   = '0;
                nline  = '0;
                npat   = pattern_sel;
            end
        end else if (ph) begin
            ncnt = cnt + 16'd1;
            unique case (state)
                VSYNC, VBACK, VFRONT: begin
                    if (cnt == 16'(LINE - 1)) begin
                        ncnt  = '0;
                        nline = line + 16'd1;
                        if (state == VSYNC && line == 16'(VSYNC_LINES - 1)) begin
                            nstate = VBACK;
                            nline  = '0;
                        end
                        if (state == VBACK && line == 16'(V_BACK - 1)) begin
                            nstate = ACTIVE;
                            nline  = '0;
                        end
                        if (state == VFRONT && line == 16'(V_FRONT - 1)) begin
                            nline = '0;
                            ndone = 1'b1;
                            if (enable) begin
                                nstate = VSYNC;
                                npat   = pattern_sel;
                            end else begin
                                nstate = IDLE;
                            end
                        end
                    end
                end
                ACTIVE: begin
                    if (cnt == 16'(2 * H_ACTIVE - 1)) begin
                        ncnt   = '0;
                        nstate = HBLANK;
                    end
                end
                HBLANK: begin
                    if (cnt == 16'(H_BLANK - 1)) begin
                        ncnt = '0;
                        if (line == 16'(V_ACTIVE - 1)) begin
                            nstate = VFRONT;
                            nline  = '0;
                        end else begin
                            nstate = ACTIVE;
                            nline  = line + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel x is ncnt >> 1; byte select is ncnt[0].
    always_comb begin
        rgb = {ncnt[7:4], nline[6:3], ncnt[4:1] ^ nline[3:0]};
`ifdef CAM_TX_BARS_EN
        if (npat) begin
            unique case (3'((int'(ncnt[15:1]) * 8) / H_ACTIVE))
                3'd0:    rgb = 12'hFFF;
                3'd1:    rgb = 12'hFF0;
                3'd2:    rgb = 12'h0FF;
                3'd3:    rgb = 12'h0F0;
                3'd4:    rgb = 12'hF0F;
                3'd5:    rgb = 12'hF00;
                3'd6:    rgb = 12'h00F;
                default: rgb = 12'h000;
            endcase
        end
`endif
        ndata = 8'h00;
        if (nstate == ACTIVE)
            ndata = ncnt[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end

`ifndef CAM_TX_BARS_EN
    logic unused_pat;
    assign unused_pat = pat;
`endif

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state      <= IDLE;
            ph         <= 1'b0;
            cnt        <= '0;
            line       <= '0;
            pat        <= 1'b0;
            href       <= 1'b0;
            c_vsync    <= 1'b0;
            out_data   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nstate;
            ph         <= (state == IDLE) ? 1'b0 : ~ph;
            cnt        <= ncnt;
            line       <= nline;
            pat        <= npat;
            href       <= (nstate == ACTIVE);
            c_vsync    <= (nstate == VSYNC);
            out_data   <= ndata;
            busy       <= (nstate != IDLE);
            frame_done <= ndone;
        end
    end

    assign pclk = ph;

endmodule
